// File: rtl/wash_controller_timed_if.sv
// Front-panel / sensor / actuator bundle for the timed washing-machine controller.
// The master side (panel and sensors) drives the requests and sensor levels,
// the slave side (the controller) drives the valves, motor, lock and status.
interface wash_controller_timed_if #(
   parameter int RINSE_W = 2
);

   // Panel requests and sensor levels
   logic               start;
   logic               pause;
   logic               door_close;
   logic               filled;
   logic               detergent_added;
   logic               drained;
   logic [RINSE_W-1:0] rinse_count;

   // Actuators and status
   logic               door_lock;
   logic               motor_on;
   logic               fill_valve_on;
   logic               drain_valve_on;
   logic               soap_wash;
   logic               water_wash;
   logic               done;
   logic               fault;
   logic [3:0]         state_o;

   modport master (
      output start, pause, door_close, filled, detergent_added, drained, rinse_count,
      input  door_lock, motor_on, fill_valve_on, drain_valve_on,
             soap_wash, water_wash, done, fault, state_o
   );

   modport slave (
      input  start, pause, door_close, filled, detergent_added, drained, rinse_count,
      output door_lock, motor_on, fill_valve_on, drain_valve_on,
             soap_wash, water_wash, done, fault, state_o
   );

endinterface

// File: rtl/wash_controller_timed.sv
// Washing-machine controller with internal phase timers, a run-time rinse count,
// a pause input and fill/drain watchdog fault detection.
// All actuator outputs are registered decodes of the state being entered, so they
// are valid in the very cycle the state register shows the new state.
module wash_controller_timed #(
   parameter int TIMER_W      = 16,
   parameter int WASH_CYCLES  = 1000,
   parameter int RINSE_CYCLES = 600,
   parameter int SPIN_CYCLES  = 400,
   parameter int WDOG_CYCLES  = 4000,
   parameter int RINSE_W      = 2
) (
   input logic                    clk,
   input logic                    reset,
   wash_controller_timed_if.slave bus
);

   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

   // Counter load values: a phase of N clocks counts N-1 down to 0
   localparam logic [TIMER_W-1:0] WASH_LOAD  = TIMER_W'(WASH_CYCLES - 1);
   localparam logic [TIMER_W-1:0] RINSE_LOAD = TIMER_W'(RINSE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] SPIN_LOAD  = TIMER_W'(SPIN_CYCLES - 1);
   localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'(WDOG_CYCLES - 1);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      LOCK    = 4'd1,
      FILL_S  = 4'd2,
      DETERG  = 4'd3,
      WASH    = 4'd4,
      DRAIN_S = 4'd5,
      FILL_R  = 4'd6,
      RINSE   = 4'd7,
      DRAIN_R = 4'd8,
      SPIN    = 4'd9,
      DONE    = 4'd10,
      FAULT   = 4'd11
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [TIMER_W-1:0]  counter;
   logic [WDOG_W-1:0]   wdog;
   logic [RINSE_W-1:0]  rinses_left;

   logic                expired;
   logic                wdog_hit;
   logic                door_watch;
   logic                timed_state;
   logic                wait_state;

   // Status flags shared by the next-state logic and the counter updates
   always_comb begin
      expired     = (counter == '0) && !bus.pause;
      wdog_hit    = (wdog == WDOG_LAST);
      door_watch  = (state != IDLE) && (state != DONE) && (state != FAULT);
      timed_state = (state == WASH) || (state == RINSE) || (state == SPIN);
      wait_state  = (state == FILL_S) || (state == FILL_R) ||
                    (state == DRAIN_S) || (state == DRAIN_R);
   end

   // Next-state decode; an open door while the program runs overrides everything
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (bus.start && bus.door_close)
               next_state = LOCK;
         end
         LOCK: begin
            if (!bus.pause)
               next_state = FILL_S;
         end
         FILL_S: begin
            if (!bus.pause) begin
               if (bus.filled)
                  next_state = DETERG;
               else if (wdog_hit)
                  next_state = FAULT;
            end
         end
         DETERG: begin
            if (!bus.pause && bus.detergent_added)
               next_state = WASH;
         end
         WASH: begin
            if (expired)
               next_state = DRAIN_S;
         end
         DRAIN_S: begin
            if (!bus.pause) begin
               if (bus.drained)
                  next_state = (rinses_left != '0) ? FILL_R : SPIN;
               else if (wdog_hit)
                  next_state = FAULT;
            end
         end
         FILL_R: begin
            if (!bus.pause) begin
               if (bus.filled)
                  next_state = RINSE;
               else if (wdog_hit)
                  next_state = FAULT;
            end
         end
         RINSE: begin
            if (expired)
               next_state = DRAIN_R;
         end
         DRAIN_R: begin
            if (!bus.pause) begin
               if (bus.drained)
                  next_state = (rinses_left > RINSE_W'(1)) ? FILL_R : SPIN;
               else if (wdog_hit)
                  next_state = FAULT;
            end
         end
         SPIN: begin
            if (expired)
               next_state = DONE;
         end
         DONE: begin
            if (!bus.start)
               next_state = IDLE;
         end
         FAULT: begin
            next_state = FAULT;
         end
         default: begin
            next_state = FAULT;
         end
      endcase

      if (door_watch && !bus.door_close)
         next_state = FAULT;
   end

   // State register, phase timer, watchdog, rinse bookkeeping and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         counter            <= '0;
         wdog               <= '0;
         rinses_left        <= '0;
         bus.door_lock      <= 1'b0;
         bus.motor_on       <= 1'b0;
         bus.fill_valve_on  <= 1'b0;
         bus.drain_valve_on <= 1'b0;
         bus.soap_wash      <= 1'b0;
         bus.water_wash     <= 1'b0;
         bus.done           <= 1'b0;
         bus.fault          <= 1'b0;
         bus.state_o        <= 4'd0;
      end else begin
         state <= next_state;

         if (state == IDLE && next_state == LOCK)
            rinses_left <= bus.rinse_count;
         else if (state == DRAIN_R && (next_state == FILL_R || next_state == SPIN))
            rinses_left <= rinses_left - RINSE_W'(1);

         if (next_state != state) begin
            case (next_state)
               WASH:    counter <= WASH_LOAD;
               RINSE:   counter <= RINSE_LOAD;
               SPIN:    counter <= SPIN_LOAD;
               default: counter <= '0;
            endcase
         end else if (timed_state && !bus.pause && counter != '0) begin
            counter <= counter - TIMER_W'(1);
         end

         if (next_state != state)
            wdog <= '0;
         else if (wait_state && !bus.pause && !wdog_hit)
            wdog <= wdog + WDOG_W'(1);

         bus.door_lock      <= (next_state != IDLE) && (next_state != DONE);
         bus.motor_on       <= ((next_state == WASH) || (next_state == RINSE) ||
                                (next_state == SPIN)) && !bus.pause;
         bus.fill_valve_on  <= (next_state == FILL_S) || (next_state == FILL_R);
         bus.drain_valve_on <= (next_state == DRAIN_S) || (next_state == DRAIN_R) ||
                               (next_state == SPIN) || (next_state == FAULT);
         bus.soap_wash      <= (next_state == WASH);
         bus.water_wash     <= (next_state == RINSE);
         bus.done           <= (next_state == DONE);
         bus.fault          <= (next_state == FAULT);
         bus.state_o        <= next_state;
      end
   end

endmodule
